// File: rtl/prog_seq_pkg.sv
// Shared types and default constants for the program run controller.
//   state_t     : run-controller state encoding
//   NPROG       : number of selectable programs
//   *_DEF       : default PC width, counter width and program entry addresses
package prog_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int unsigned NPROG      = 3;
    localparam int unsigned L_DEF      = 10;
    localparam int unsigned CW_DEF     = 16;
    localparam int unsigned ENTRY0_DEF = 1;
    localparam int unsigned ENTRY1_DEF = 2;
    localparam int unsigned ENTRY2_DEF = 4;

endpackage

// File: rtl/prog_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
//   Clk, Reset : clock, synchronous active-low reset
//   clr        : clear to zero (has priority over en)
//   en         : count up by one, stopping at MAXCYC
//   count      : registered count value
//   tc_c       : combinational terminal count, high when count == MAXCYC-1
module sat_counter #(
    parameter int unsigned CW     = 16,
    parameter int unsigned MAXCYC = (2 ** CW) - 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          tc_c
);

    localparam logic [CW-1:0] SAT_VAL = CW'(MAXCYC);
    localparam logic [CW-1:0] TC_VAL  = CW'(MAXCYC - 1);

    // Count register; holds at SAT_VAL instead of wrapping.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != SAT_VAL)) begin
            count <= count + CW'(1);
        end
    end

    // Terminal count lets the watchdog end RUN on the edge that reaches MAXCYC.
    assign tc_c = (count == TC_VAL);

endmodule

// File: rtl/prog_sequencer.sv
// Run controller for the program counter: arms a selected program, drives the
// PC load/hold/target controls, and reports completion, cycle count and a
// watchdog timeout.
//   Clk, Reset  : clock, synchronous active-low reset
//   Start       : host request level (high arms, falling releases the run)
//   ProgSel     : program index, sampled when a request is accepted
//   Halt        : decoder terminating-instruction indication
//   PcLoad      : PC loads PcTarget at next edge
//   PcTarget    : entry address to load (0 when PcLoad is low)
//   PcHold      : PC holds its value
//   Busy        : program armed or running
//   Done        : last program finished
//   Timeout     : last program ended by the watchdog
//   BadSel      : last request had an out-of-range ProgSel
//   ActiveProg  : index of the armed or last program
//   CycleCount  : RUN cycles of the current or last program
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int unsigned L      = prog_seq_pkg::L_DEF,
    parameter int unsigned NPROG  = prog_seq_pkg::NPROG,
    parameter int unsigned ENTRY0 = prog_seq_pkg::ENTRY0_DEF,
    parameter int unsigned ENTRY1 = prog_seq_pkg::ENTRY1_DEF,
    parameter int unsigned ENTRY2 = prog_seq_pkg::ENTRY2_DEF,
    parameter int unsigned CW     = prog_seq_pkg::CW_DEF,
    parameter int unsigned MAXCYC = (2 ** CW) - 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [1:0]    ProgSel,
    input  logic          Halt,
    output logic          PcLoad,
    output logic [L-1:0]  PcTarget,
    output logic          PcHold,
    output logic          Busy,
    output logic          Done,
    output logic          Timeout,
    output logic          BadSel,
    output logic [1:0]    ActiveProg,
    output logic [CW-1:0] CycleCount
);

    state_t         state, state_n;
    logic           pc_load_n;
    logic [L-1:0]   pc_target_n;
    logic           pc_hold_n;
    logic           busy_n;
    logic           done_n;
    logic           timeout_n;
    logic           bad_sel_n;
    logic [1:0]     active_prog_n;
    logic           cnt_clr;
    logic           cnt_en;
    logic           cnt_tc_c;
    logic           sel_ok_c;

    function automatic logic [L-1:0] entry_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return L'(ENTRY0);
            2'd1:    return L'(ENTRY1);
            default: return L'(ENTRY2);
        endcase
    endfunction

    assign sel_ok_c = (32'(ProgSel) < NPROG);

    // RUN-cycle counter doubling as the watchdog.
    sat_counter #(
        .CW     (CW),
        .MAXCYC (MAXCYC)
    ) u_cycle_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (CycleCount),
        .tc_c  (cnt_tc_c)
    );

    // State and output registers; outputs are the registered decode of state_n.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state      <= S_IDLE;
            PcLoad     <= 1'b0;
            PcTarget   <= '0;
            PcHold     <= 1'b1;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Timeout    <= 1'b0;
            BadSel     <= 1'b0;
            ActiveProg <= 2'd0;
        end else begin
            state      <= state_n;
            PcLoad     <= pc_load_n;
            PcTarget   <= pc_target_n;
            PcHold     <= pc_hold_n;
            Busy       <= busy_n;
            Done       <= done_n;
            Timeout    <= timeout_n;
            BadSel     <= bad_sel_n;
            ActiveProg <= active_prog_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n       = state;
        pc_load_n     = 1'b0;
        pc_target_n   = '0;
        pc_hold_n     = 1'b1;
        busy_n        = 1'b0;
        done_n        = Done;
        timeout_n     = Timeout;
        bad_sel_n     = BadSel;
        active_prog_n = ActiveProg;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    if (sel_ok_c) begin
                        state_n       = S_ARMED;
                        active_prog_n = ProgSel;
                        done_n        = 1'b0;
                        timeout_n     = 1'b0;
                        bad_sel_n     = 1'b0;
                        cnt_clr       = 1'b1;
                    end else begin
                        bad_sel_n = 1'b1;
                    end
                end
            end
            S_ARMED: begin
                if (!Start) begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                cnt_en = 1'b1;
                // Halt takes priority over the watchdog on the same cycle.
                if (Halt) begin
                    state_n   = S_DONE;
                    done_n    = 1'b1;
                    timeout_n = 1'b0;
                end else if (cnt_tc_c) begin
                    state_n   = S_DONE;
                    done_n    = 1'b1;
                    timeout_n = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        case (state_n)
            S_ARMED: begin
                pc_load_n   = 1'b1;
                pc_target_n = entry_of(active_prog_n);
                pc_hold_n   = 1'b0;
                busy_n      = 1'b1;
            end
            S_RUN: begin
                pc_hold_n = 1'b0;
                busy_n    = 1'b1;
            end
            default: begin
                pc_hold_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer (MAXCYC reduced to 20).
module tb_prog_sequencer;
    import prog_seq_pkg::*;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [1:0]  ProgSel;
    logic        Halt;
    logic        PcLoad;
    logic [9:0]  PcTarget;
    logic        PcHold;
    logic        Busy;
    logic        Done;
    logic        Timeout;
    logic        BadSel;
    logic [1:0]  ActiveProg;
    logic [15:0] CycleCount;

    typedef struct packed {
        logic        load;
        logic [9:0]  tgt;
        logic        hold;
        logic        busy;
        logic        done;
        logic        to;
        logic        bad;
        logic [1:0]  ap;
        logic [15:0] cc;
    } outs_t;

    typedef struct {
        logic       start;
        logic [1:0] sel;
        logic       halt;
        outs_t      exp;
        string      name;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];

    prog_sequencer #(
        .L      (10),
        .NPROG  (3),
        .ENTRY0 (1),
        .ENTRY1 (2),
        .ENTRY2 (4),
        .CW     (16),
        .MAXCYC (20)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .ProgSel    (ProgSel),
        .Halt       (Halt),
        .PcLoad     (PcLoad),
        .PcTarget   (PcTarget),
        .PcHold     (PcHold),
        .Busy       (Busy),
        .Done       (Done),
        .Timeout    (Timeout),
        .BadSel     (BadSel),
        .ActiveProg (ActiveProg),
        .CycleCount (CycleCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic outs_t o_idle(input logic [1:0] ap, input logic bad);
        return '{load: 1'b0, tgt: 10'd0, hold: 1'b1, busy: 1'b0, done: 1'b0,
                 to: 1'b0, bad: bad, ap: ap, cc: 16'd0};
    endfunction

    function automatic outs_t o_arm(input logic [1:0] ap, input logic [9:0] tgt);
        return '{load: 1'b1, tgt: tgt, hold: 1'b0, busy: 1'b1, done: 1'b0,
                 to: 1'b0, bad: 1'b0, ap: ap, cc: 16'd0};
    endfunction

    function automatic outs_t o_run(input logic [1:0] ap, input logic [15:0] cc);
        return '{load: 1'b0, tgt: 10'd0, hold: 1'b0, busy: 1'b1, done: 1'b0,
                 to: 1'b0, bad: 1'b0, ap: ap, cc: cc};
    endfunction

    function automatic outs_t o_done(input logic [1:0] ap, input logic [15:0] cc,
                                     input logic to, input logic bad);
        return '{load: 1'b0, tgt: 10'd0, hold: 1'b1, busy: 1'b0, done: 1'b1,
                 to: to, bad: bad, ap: ap, cc: cc};
    endfunction

    function automatic vec_t mk(input logic s, input logic [1:0] sel, input logic h,
                                input outs_t exp, input string name);
        vec_t v;
        v.start = s;
        v.sel   = sel;
        v.halt  = h;
        v.exp   = exp;
        v.name  = name;
        return v;
    endfunction

    task automatic check(input string name, input outs_t exp);
        outs_t got;
        got = {PcLoad, PcTarget, PcHold, Busy, Done, Timeout, BadSel, ActiveProg, CycleCount};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got load=%0b tgt=%0d hold=%0b busy=%0b done=%0b to=%0b bad=%0b ap=%0d cc=%0d; expected load=%0b tgt=%0d hold=%0b busy=%0b done=%0b to=%0b bad=%0b ap=%0d cc=%0d",
                     name, got.load, got.tgt, got.hold, got.busy, got.done, got.to, got.bad, got.ap, got.cc,
                     exp.load, exp.tgt, exp.hold, exp.busy, exp.done, exp.to, exp.bad, exp.ap, exp.cc);
        end
    endtask

    // Drive inputs away from the edge, then sample just after it.
    task automatic step(input logic s, input logic [1:0] sel, input logic h);
        @(negedge Clk);
        Start   = s;
        ProgSel = sel;
        Halt    = h;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset   = 1'b0;
        Start   = 1'b0;
        ProgSel = 2'd0;
        Halt    = 1'b0;

        // Program 2: three-cycle arm, halt on the 10th RUN cycle.
        vecs.push_back(mk(1'b1, 2'd2, 1'b0, o_arm(2'd2, 10'd4), "arm2_c1"));
        vecs.push_back(mk(1'b1, 2'd0, 1'b0, o_arm(2'd2, 10'd4), "arm2_c2_selchg"));
        vecs.push_back(mk(1'b1, 2'd1, 1'b0, o_arm(2'd2, 10'd4), "arm2_c3_selchg"));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, o_run(2'd2, 16'd0), "run2_enter"));
        for (int i = 1; i <= 10; i++) begin
            if (i == 10)
                vecs.push_back(mk(1'b0, 2'd0, 1'b1, o_done(2'd2, 16'd10, 1'b0, 1'b0), "run2_halt"));
            else if (i == 3)
                vecs.push_back(mk(1'b1, 2'd1, 1'b0, o_run(2'd2, 16'(i)), "run2_start_ignored"));
            else
                vecs.push_back(mk(1'b0, 2'd0, 1'b0, o_run(2'd2, 16'(i)), $sformatf("run2_c%0d", i)));
        end
        vecs.push_back(mk(1'b0, 2'd0, 1'b1, o_done(2'd2, 16'd10, 1'b0, 1'b0), "done_halt_ignored"));
        // Out-of-range select while DONE, then a valid one-cycle re-arm.
        vecs.push_back(mk(1'b1, 2'(NPROG), 1'b0, o_done(2'd2, 16'd10, 1'b0, 1'b1), "done_badsel"));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, o_done(2'd2, 16'd10, 1'b0, 1'b1), "done_badsel_sticky"));
        vecs.push_back(mk(1'b1, 2'd0, 1'b0, o_arm(2'd0, 10'd1), "rearm0"));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, o_run(2'd0, 16'd0), "run0_enter"));
        // Watchdog: no Halt, DONE with Timeout after 20 RUN cycles.
        for (int i = 1; i <= 20; i++) begin
            if (i == 20)
                vecs.push_back(mk(1'b0, 2'd0, 1'b0, o_done(2'd0, 16'd20, 1'b1, 1'b0), "wd_timeout"));
            else
                vecs.push_back(mk(1'b0, 2'd0, 1'b0, o_run(2'd0, 16'(i)), $sformatf("wd_c%0d", i)));
        end
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, o_done(2'd0, 16'd20, 1'b1, 1'b0), "wd_frozen"));

        // Reset for two edges.
        @(posedge Clk);
        @(posedge Clk);
        #1;
        check("reset", o_idle(2'd0, 1'b0));
        @(negedge Clk);
        Reset = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].start, vecs[i].sel, vecs[i].halt);
            check(vecs[i].name, vecs[i].exp);
        end

        // Halt on the same cycle the watchdog limit is reached.
        step(1'b1, 2'd1, 1'b0);
        check("lim_arm1", o_arm(2'd1, 10'd2));
        step(1'b0, 2'd0, 1'b0);
        for (int i = 1; i <= 19; i++) begin
            step(1'b0, 2'd0, 1'b0);
        end
        check("lim_c19", o_run(2'd1, 16'd19));
        step(1'b0, 2'd0, 1'b1);
        check("lim_halt_wins", o_done(2'd1, 16'd20, 1'b0, 1'b0));

        // Reset in the middle of RUN, with Start high across the reset edge.
        step(1'b1, 2'd0, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 2'd0, 1'b0);
        end
        check("midrun_c5", o_run(2'd0, 16'd5));
        @(negedge Clk);
        Reset = 1'b0;
        Start = 1'b1;
        ProgSel = 2'd1;
        @(posedge Clk);
        #1;
        check("midrun_reset", o_idle(2'd0, 1'b0));
        @(negedge Clk);
        Reset = 1'b1;
        Start = 1'b0;

        // Out-of-range select from IDLE; Halt in IDLE has no effect.
        step(1'b1, 2'd3, 1'b0);
        check("idle_badsel", o_idle(2'd0, 1'b1));
        step(1'b1, 2'd3, 1'b1);
        check("idle_badsel_hold", o_idle(2'd0, 1'b1));
        step(1'b0, 2'd0, 1'b1);
        check("idle_halt_ignored", o_idle(2'd0, 1'b1));
        step(1'b1, 2'd1, 1'b0);
        check("idle_valid_clears_bad", o_arm(2'd1, 10'd2));
        step(1'b0, 2'd0, 1'b0);
        check("run1_enter", o_run(2'd1, 16'd0));
        step(1'b0, 2'd0, 1'b1);
        check("run1_halt_first", o_done(2'd1, 16'd1, 1'b0, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Run controller for the program counter. Accepts a host start request with a program selector and drives the PC load, hold and target controls so the selected program begins at its entry address. Monitors the decoder's halt indication and reports completion, a cycle count and a watchdog timeout to the host. Sits between the top-level host interface and the PC register, and replaces the hardcoded start sequencing.

## Interface
Parameters:
- L, 10, PC width
- NPROG, 3, number of selectable programs
- ENTRY0 / ENTRY1 / ENTRY2, 1 / 2 / 4, entry addresses of programs 0 / 1 / 2
- CW, 16, cycle-counter width
- MAXCYC, 2**CW-1, watchdog limit in RUN cycles

Ports:
- Clk  in  1  single clock; all state changes on posedge
- Reset  in  1  synchronous, active-low (0 = reset), sampled on posedge Clk
- Start  in  1  host request level; hold high to arm, release to launch
- ProgSel  in  2  program index, sampled on the first Start-high cycle
- Halt  in  1  decoder: terminating instruction executed this cycle
- PcLoad  out  1  PC loads PcTarget at next edge
- PcTarget  out  L  entry address to load
- PcHold  out  1  PC holds its value (no increment, no branch)
- Busy  out  1  program armed or running
- Done  out  1  level; last program finished, held until next arm
- Timeout  out  1  level; last program ended by the watchdog
- BadSel  out  1  sticky; last request had ProgSel >= NPROG
- ActiveProg  out  2  index of the armed or last program
- CycleCount  out  CW  RUN cycles of the current or last program

## Operation
- States: IDLE, ARMED, RUN, DONE.
- IDLE: PcHold=1. If Start=1 and ProgSel<NPROG, latch ProgSel, go to ARMED, clear CycleCount/Done/Timeout/BadSel. If Start=1 and ProgSel>=NPROG, set BadSel and stay in IDLE.
- ARMED: PcLoad=1, PcTarget=ENTRY[ActiveProg], PcHold=0, Busy=1. ProgSel changes are ignored. Start=0 moves to RUN.
- RUN: PcLoad=0, PcHold=0, Busy=1. CycleCount increments each cycle. Halt=1 moves to DONE. If CycleCount==MAXCYC-1 without Halt, move to DONE and set Timeout. Halt and the limit in the same cycle: Halt wins, Timeout=0. Start is ignored.
- DONE: PcHold=1, Done=1, CycleCount frozen. Start=1 is handled exactly as in IDLE.
- Halt outside RUN is ignored.
- CycleCount saturates at MAXCYC and never wraps.
- PcTarget=0 whenever PcLoad=0.

## Timing
- Reset=0 at an edge: state IDLE; PcLoad=0, PcTarget=0, PcHold=1, Busy=0, Done=0, Timeout=0, BadSel=0, ActiveProg=0, CycleCount=0. This applies from any state, including mid-RUN.
- Outputs decode from registered state only; there is no combinational path from input to output.
- Start=1 sampled at edge n: ARMED after n, and the PC holds ENTRY at edge n+1. The PC reloads ENTRY every edge while Start stays high.
- Start=0 sampled at edge m: RUN after m. The first increment from ENTRY happens at edge m+1.
- Halt=1 sampled at edge k: DONE after k. CycleCount includes the Halt cycle. PcHold=1 from cycle k+1, so the PC is frozen at its edge-k value.
- Minimum arm pulse is 1 cycle. Re-arm from DONE has 1 cycle of latency, the same as from IDLE.

## Structure
- Package prog_seq_pkg holds the state enum (state_t), NPROG and the default entry-address constants. Both the top level and the bench import it.
- One sub-module, sat_counter: a CW-bit counter with clear, enable and saturate, plus a terminal-count output that feeds the watchdog.
- Expected size is about 150–250 lines of RTL.

## Test plan
- Reset=0 for 2 cycles, then 1 → all outputs at their reset values; PcHold=1; state IDLE.
- ProgSel=2, Start high for 3 cycles then low; Halt after 10 RUN cycles → PcLoad=1 with PcTarget=4 for 3 cycles; Done=1; CycleCount=10; ActiveProg=2; Timeout=0.
- MAXCYC=20, ProgSel=0, Halt never asserted → DONE after 20 RUN cycles; Timeout=1; CycleCount=20; PcHold=1.
- Halt on the same cycle the limit is reached → Done=1, Timeout=0.
- ProgSel=3 with Start=1 → BadSel=1, stays IDLE, PcLoad never asserted. A following valid request clears BadSel.
- Reset=0 mid-RUN at CycleCount=5 → IDLE next cycle with CycleCount=0. Start=1 during RUN and Halt=1 during IDLE have no effect.
